// File: rtl/xlib_rs_fifo_lvl.sv
// Register-file FIFO with occupancy level, almost-full/empty flags and sticky
// overflow/underflow errors; head is either a shift register slot or a RAM mux.
module xlib_rs_fifo_lvl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FFOUT  = 1,
  parameter int unsigned AFULL  = 3,
  parameter int unsigned AEMPTY = 1,
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             nf,
  output logic             ne,
  output logic [LW-1:0]    lvl,
  output logic             af,
  output logic             ae,
  output logic             ovf,
  output logic             udf,
  input  logic             err_clr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          re_ok;
  logic          we_ok;
  logic [LW-1:0] lvl_nxt;

  // Status flags decode the registered level only.
  assign ne = (lvl != '0);
  assign nf = (lvl != LW'(DEPTH));
  assign af = (lvl >= LW'(AFULL));
  assign ae = (lvl <= LW'(AEMPTY));

  assign re_ok   = re & ne;
  assign we_ok   = we & (nf | re_ok);
  assign lvl_nxt = lvl + LW'(we_ok) - LW'(re_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (!clr_n) begin
      lvl <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      lvl <= lvl_nxt;
      // A new error in the same cycle as err_clr keeps the flag set.
      if (we & ~we_ok) ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (re & ~ne) udf <= 1'b1;
      else if (err_clr) udf <= 1'b0;
    end
  end

  if (FFOUT != 0) begin : g_shift
    logic [WIDTH-1:0] slot    [DEPTH];
    logic [WIDTH-1:0] shifted [DEPTH];
    logic [LW-1:0]    wr_idx;

    // Incoming data lands just behind the surviving entries.
    assign wr_idx = lvl - LW'(re_ok);
    assign q      = slot[0];

    always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) shifted[i] = slot[i];
      for (int i = 0; i < int'(DEPTH) - 1; i++) shifted[i] = slot[i + 1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) slot[i] <= '0;
      end else if (clr_n) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (we_ok && (wr_idx == LW'(i))) slot[i] <= d;
          else if (re_ok) slot[i] <= shifted[i];
        end
      end
    end
  end else begin : g_circ
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wa;
    logic [AW-1:0]    ra;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign q = mem[ra];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (clr_n && we_ok) begin
        mem[wa] <= d;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wa <= '0;
        ra <= '0;
      end else if (!clr_n) begin
        wa <= '0;
        ra <= '0;
      end else begin
        if (we_ok) wa <= ptr_inc(wa);
        if (re_ok) ra <= ptr_inc(ra);
      end
    end
  end

endmodule

// File: tb/tb_xlib_rs_fifo_lvl.sv
// Bench for xlib_rs_fifo_lvl: shift and circular variants of a 4-deep FIFO plus
// a 3-deep circular one, all driven alike and checked against queue models.
module tb_xlib_rs_fifo_lvl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_n = 1'b1;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] d = 8'h00;

  logic [7:0] q_a, q_b, q_c;
  logic [2:0] lvl_a, lvl_b;
  logic [1:0] lvl_c;
  logic nf_a, ne_a, af_a, ae_a, ovf_a, udf_a;
  logic nf_b, ne_b, af_b, ae_b, ovf_b, udf_b;
  logic nf_c, ne_c, af_c, ae_c, ovf_c, udf_c;

  int checks = 0;
  int errors = 0;

  // Reference models: index 0 = depth 4, index 1 = depth 3.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  bit         movf[2];
  bit         mudf[2];

  always #5 clk = ~clk;

  xlib_rs_fifo_lvl #(.WIDTH(8), .DEPTH(4), .FFOUT(1), .AFULL(3), .AEMPTY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .we(we), .re(re), .d(d), .q(q_a),
    .nf(nf_a), .ne(ne_a), .lvl(lvl_a), .af(af_a), .ae(ae_a), .ovf(ovf_a), .udf(udf_a),
    .err_clr(err_clr));

  xlib_rs_fifo_lvl #(.WIDTH(8), .DEPTH(4), .FFOUT(0), .AFULL(3), .AEMPTY(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .we(we), .re(re), .d(d), .q(q_b),
    .nf(nf_b), .ne(ne_b), .lvl(lvl_b), .af(af_b), .ae(ae_b), .ovf(ovf_b), .udf(udf_b),
    .err_clr(err_clr));

  xlib_rs_fifo_lvl #(.WIDTH(8), .DEPTH(3), .FFOUT(0), .AFULL(2), .AEMPTY(0)) u_c (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .we(we), .re(re), .d(d), .q(q_c),
    .nf(nf_c), .ne(ne_c), .lvl(lvl_c), .af(af_c), .ae(ae_c), .ovf(ovf_c), .udf(udf_c),
    .err_clr(err_clr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int msize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [7:0] mfront(input int k);
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic mclear(input int k);
    if (k == 0) mq0.delete(); else mq1.delete();
    movf[k] = 1'b0;
    mudf[k] = 1'b0;
  endtask

  // One clock of the behavioural FIFO, using the inputs about to be sampled.
  task automatic model_step(input int k, input int dep);
    int  n;
    bit  rok, wok;
    n = msize(k);
    if (!clr_n) begin
      mclear(k);
      return;
    end
    rok = re && (n > 0);
    wok = we && ((n < dep) || rok);
    if (rok) begin
      if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
    end
    if (wok) begin
      if (k == 0) mq0.push_back(d); else mq1.push_back(d);
    end
    if (we && !wok) movf[k] = 1'b1;
    else if (err_clr) movf[k] = 1'b0;
    if (re && (n == 0)) mudf[k] = 1'b1;
    else if (err_clr) mudf[k] = 1'b0;
  endtask

  task automatic check_inst(input string nm, input int k, input int dep, input int aft,
                            input int aet, input logic [31:0] lv, input logic nfo,
                            input logic neo, input logic afo, input logic aeo,
                            input logic ov, input logic ud, input logic [7:0] qo);
    int n;
    n = msize(k);
    chk({nm, "_lvl"}, lv, 32'(n));
    chk({nm, "_ne"}, 32'(neo), 32'(n != 0));
    chk({nm, "_nf"}, 32'(nfo), 32'(n != dep));
    chk({nm, "_af"}, 32'(afo), 32'(n >= aft));
    chk({nm, "_ae"}, 32'(aeo), 32'(n <= aet));
    chk({nm, "_ovf"}, 32'(ov), 32'(movf[k]));
    chk({nm, "_udf"}, 32'(ud), 32'(mudf[k]));
    if (n != 0) chk({nm, "_q"}, 32'(qo), 32'(mfront(k)));
  endtask

  task automatic check_all();
    check_inst("a", 0, 4, 3, 1, 32'(lvl_a), nf_a, ne_a, af_a, ae_a, ovf_a, udf_a, q_a);
    check_inst("b", 0, 4, 3, 1, 32'(lvl_b), nf_b, ne_b, af_b, ae_b, ovf_b, udf_b, q_b);
    check_inst("c", 1, 3, 2, 0, 32'(lvl_c), nf_c, ne_c, af_c, ae_c, ovf_c, udf_c, q_c);
  endtask

  // Drive one cycle's inputs, advance the models, check after the edge.
  task automatic cyc(input bit w, input bit r, input logic [7:0] dv,
                     input bit clr = 1'b1, input bit ec = 1'b0);
    we = w; re = r; d = dv; clr_n = clr; err_clr = ec;
    model_step(0, 4);
    model_step(1, 3);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input bit w, input bit r);
    we = w; re = r; d = 8'hEE;
    rst_n = 1'b0;
    #1;
    mclear(0);
    mclear(1);
    check_all();
    chk("a_q_rst", 32'(q_a), 32'h0);
    chk("b_q_rst", 32'(q_b), 32'h0);
    chk("c_q_rst", 32'(q_c), 32'h0);
    @(negedge clk);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #2;
    do_reset(1'b0, 1'b0);

    // Reset asserted in the middle of a burst with requests pending.
    cyc(1, 0, 8'hAA);
    cyc(1, 0, 8'hBB);
    do_reset(1'b1, 1'b1);

    // Fill and drain in order.
    cyc(1, 0, 8'h11);
    cyc(1, 0, 8'h22);
    cyc(1, 0, 8'h33);
    chk("a_af_at3", 32'(af_a), 32'h1);
    cyc(1, 0, 8'h44);
    chk("a_nf_at4", 32'(nf_a), 32'h0);
    chk("a_q_head", 32'(q_a), 32'h11);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00);
    chk("a_ne_end", 32'(ne_a), 32'h0);

    // Full with simultaneous write and read.
    cyc(1, 0, 8'h11);
    cyc(1, 0, 8'h22);
    cyc(1, 0, 8'h33);
    cyc(1, 0, 8'h44);
    cyc(1, 1, 8'h55);
    chk("a_lvl_full_rw", 32'(lvl_a), 32'h4);
    chk("a_q_after_rw", 32'(q_a), 32'h22);
    chk("b_q_after_rw", 32'(q_b), 32'h22);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h00);
    chk("a_q_fourth", 32'(q_a), 32'h55);

    // Overflow on full write, then drain.
    cyc(0, 1, 8'h00);
    cyc(1, 0, 8'hA1);
    cyc(1, 0, 8'hA2);
    cyc(1, 0, 8'hA3);
    cyc(1, 0, 8'hA4);
    cyc(1, 0, 8'hEE);
    chk("a_ovf_set", 32'(ovf_a), 32'h1);
    chk("a_q_kept", 32'(q_a), 32'hA1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00);

    // Underflow on empty read with a concurrent write.
    cyc(1, 1, 8'h66);
    chk("a_udf_set", 32'(udf_a), 32'h1);
    chk("a_lvl_one", 32'(lvl_a), 32'h1);
    chk("a_q_66", 32'(q_a), 32'h66);
    cyc(0, 0, 8'h00, 1'b1, 1'b1);
    chk("a_ovf_clr", 32'(ovf_a), 32'h0);
    chk("a_udf_clr", 32'(udf_a), 32'h0);

    // New error coinciding with err_clr keeps the flag set.
    cyc(1, 0, 8'h01);
    cyc(1, 0, 8'h02);
    cyc(1, 0, 8'h03);
    cyc(1, 0, 8'h04, 1'b1, 1'b1);
    chk("a_ovf_setwins", 32'(ovf_a), 32'h1);

    // Synchronous clear at level 2 with ovf set and a write pending.
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    chk("a_lvl_two", 32'(lvl_a), 32'h2);
    cyc(1, 0, 8'h99, 1'b0);
    chk("a_lvl_clr", 32'(lvl_a), 32'h0);
    chk("a_ovf_clrn", 32'(ovf_a), 32'h0);
    cyc(1, 0, 8'h77);
    chk("a_q_77", 32'(q_a), 32'h77);
    chk("b_q_77", 32'(q_b), 32'h77);
    cyc(0, 1, 8'h00);

    // Randomised traffic; the 3-deep circular instance wraps repeatedly.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
          ($urandom_range(0, 49) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
